store_merge_unit: RTL and testbench

- Back end of the sub-word store split. The instruction stream turns every sb/sh into a word load from the same address, followed by the original store.
- This block receives the store request and performs the word read, byte/half merge and full-word write as a read-modify-write sequence.
- It sits between the execute stage and the word-only data memory port. Only 32-bit aligned writes ever reach memory.

---
 rtl/store_merge_unit.sv | 157 +++++++++++++++
 tb/tb_store_merge_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - sub-word store read-modify-write merge onto a word-only memory port
// Optional last-write forwarding enabled by STORE_MERGE_FWD_EN.
module store_merge_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [2:0]        st_funct3,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_done,
    output logic              st_err,
    output logic              mem_rd_valid,
    input  logic              mem_rd_ready,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
    state_t state, state_nx;

    logic              half_q;
    logic [1:0]        lane_q;
    logic [15:0]       data_q;
    logic              req_bad;
    logic              accept;
    logic              is_sw;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_word;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [15:0] d,
                                                input logic is_half,
                                                input logic [1:0] lane);
        logic [DATA_W-1:0] w;
        w = old;
        if (is_half) begin
            if (lane[1]) w[31:16] = d;
            else         w[15:0]  = d;
        end else begin
            case (lane)
                2'd0:    w[7:0]   = d[7:0];
                2'd1:    w[15:8]  = d[7:0];
                2'd2:    w[23:16] = d[7:0];
                default: w[31:24] = d[7:0];
            endcase
        end
        return w;
    endfunction

    always_comb begin
        req_bad = 1'b1;
        case (st_funct3)
            F3_SB:   req_bad = 1'b0;
            F3_SH:   req_bad = st_addr[0];
            F3_SW:   req_bad = (st_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    assign accept = st_valid && (state == IDLE);
    assign is_sw  = (st_funct3 == F3_SW);

`ifdef STORE_MERGE_FWD_EN
    logic              hold_valid;
    logic [ADDR_W-3:0] hold_addr;
    logic [DATA_W-1:0] hold_data;

    // Memory is private to this port, so the last written word is authoritative.
    assign fwd_hit  = hold_valid && (hold_addr == st_addr[ADDR_W-1:2]);
    assign fwd_word = hold_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
        end else if (state == WR_REQ && mem_wr_ready) begin
            hold_valid <= 1'b1;
            hold_addr  <= mem_addr[ADDR_W-1:2];
            hold_data  <= mem_wdata;
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_word = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        st_ready     = 1'b0;
        mem_rd_valid = 1'b0;
        mem_wr_valid = 1'b0;
        case (state)
            IDLE: begin
                st_ready = 1'b1;
                if (accept && !req_bad) begin
                    if (is_sw || fwd_hit) state_nx = WR_REQ;
                    else                  state_nx = RD_REQ;
                end
            end
            RD_REQ: begin
                mem_rd_valid = 1'b1;
                if (mem_rd_ready) state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rdata_valid) state_nx = WR_REQ;
            end
            WR_REQ: begin
                mem_wr_valid = 1'b1;
                if (mem_wr_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            half_q    <= 1'b0;
            lane_q    <= 2'b00;
            data_q    <= '0;
        end else begin
            st_done <= (state == WR_REQ) && mem_wr_ready;
            st_err  <= accept && req_bad;
            if (accept && !req_bad) begin
                mem_addr <= {st_addr[ADDR_W-1:2], 2'b00};
                half_q   <= st_funct3[0];
                lane_q   <= st_addr[1:0];
                data_q   <= st_data[15:0];
                if (is_sw)        mem_wdata <= st_data;
                else if (fwd_hit) mem_wdata <= merge(fwd_word, st_data[15:0], st_funct3[0], st_addr[1:0]);
            end else if (state == RD_WAIT && mem_rdata_valid) begin
                mem_wdata <= merge(mem_rdata, data_q, half_q, lane_q);
            end
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// tb/tb_store_merge_unit.sv - randomized self-checking bench for store_merge_unit
module tb_store_merge_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [2:0]  st_funct3 = 3'b000;
    logic [31:0] st_addr = 32'h0;
    logic [31:0] st_data = 32'h0;
    logic        st_done, st_err;
    logic        mem_rd_valid;
    logic        mem_rd_ready = 1'b0;
    logic        mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_wr_valid;
    logic        mem_wr_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_merge_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_funct3(st_funct3),
        .st_addr(st_addr), .st_data(st_data), .st_done(st_done), .st_err(st_err),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    // Responder memory (what the bench memory holds) and reference memory (what it should hold).
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    bit          last_valid = 1'b0;
    logic [31:0] last_wa = 32'h0;

    int          obs_reads, obs_writes, obs_done_cnt, obs_err_cnt, obs_done_cyc, obs_err_cyc, obs_bad;
    logic [31:0] obs_rd_addr, obs_wr_addr, obs_wdata;
    bit          obs_ready_after;

    function automatic logic [31:0] ref_word(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] data, input logic [31:0] old);
        logic [7:0] b [4];
        int k;
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        k = int'(addr % 4);
        if (f3 == 3'd0) b[k] = data[7:0];
        else if (f3 == 3'd1) begin
            b[k] = data[7:0];
            b[k+1] = data[15:8];
        end else for (int i = 0; i < 4; i++) b[i] = data[8*i +: 8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                               input int rd_dly, input int ret_dly, input int wr_dly,
                               output bit legal, output int e_reads, output int e_lat,
                               output logic [31:0] e_w, output logic [31:0] e_wa);
        bit hit;
        logic [31:0] old;
        e_wa = addr & 32'hFFFF_FFFC;
        legal = (f3 == 3'd0) || (f3 == 3'd1 && addr[0] == 1'b0) || (f3 == 3'd2 && addr[1:0] == 2'b00);
        e_reads = 0;
        e_lat = 1;
        e_w = 32'h0;
        if (!legal) return;
        hit = 1'b0;
`ifdef STORE_MERGE_FWD_EN
        hit = last_valid && (last_wa == e_wa) && (f3 != 3'd2);
`endif
        e_reads = (f3 != 3'd2 && !hit) ? 1 : 0;
        old = ref_mem.exists(e_wa) ? ref_mem[e_wa] : 32'h0;
        e_w = ref_word(f3, addr, data, old);
        ref_mem[e_wa] = e_w;
        last_valid = 1'b1;
        last_wa = e_wa;
        e_lat = (e_reads == 1) ? 3 + rd_dly + ret_dly + wr_dly : 2 + wr_dly;
    endtask

    // Issue one request and act as the memory; records what was observed, per cycle after acceptance.
    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                            input int rd_dly, input int ret_dly, input int wr_dly,
                            input bit expect_err, input bit noise);
        int rd_w, wr_w, ret_in;
        bit rd_pend, wr_pend, outst, have_addr;
        logic [31:0] held, ret_addr;
        rd_w = 0; wr_w = 0; ret_in = 0;
        rd_pend = 0; wr_pend = 0; outst = 0; have_addr = 0;
        held = 0; ret_addr = 0;
        obs_reads = 0; obs_writes = 0; obs_done_cnt = 0; obs_err_cnt = 0; obs_bad = 0;
        obs_done_cyc = -1; obs_err_cyc = -1; obs_ready_after = 0;
        obs_rd_addr = 0; obs_wr_addr = 0; obs_wdata = 0;
        @(negedge clk);
        mem_rd_ready = 0; mem_wr_ready = 0; mem_rdata_valid = 0;
        st_valid = 1; st_funct3 = f3; st_addr = addr; st_data = data;
        @(negedge clk);
        st_valid = 0; st_funct3 = 3'($urandom); st_addr = $urandom; st_data = $urandom;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk);
            mem_rd_ready = 0; mem_wr_ready = 0; mem_rdata_valid = 0; mem_rdata = $urandom;
            if (st_done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) begin obs_done_cyc = n; obs_ready_after = st_ready; end
            end
            if (st_err) begin obs_err_cnt++; if (obs_err_cyc < 0) obs_err_cyc = n; end
            if (mem_rd_valid && mem_wr_valid) obs_bad++;
            if (rd_pend && !mem_rd_valid) obs_bad++;
            if (wr_pend && !mem_wr_valid) obs_bad++;
            rd_pend = 0; wr_pend = 0;
            if (mem_rd_valid || mem_wr_valid) begin
                if (have_addr && mem_addr !== held) obs_bad++;
                held = mem_addr; have_addr = 1;
            end
            if (!expect_err && obs_done_cyc < 0 && st_ready !== 1'b0) obs_bad++;
            if (noise && !outst && $urandom_range(0, 1) == 1) mem_rdata_valid = 1;
            if (ret_in > 0) begin
                ret_in--;
                if (ret_in == 0) begin
                    mem_rdata_valid = 1;
                    mem_rdata = mem.exists(ret_addr) ? mem[ret_addr] : 32'h0;
                    outst = 0;
                end
            end
            if (mem_rd_valid) begin
                if (rd_w >= rd_dly) begin
                    mem_rd_ready = 1; obs_reads++; obs_rd_addr = mem_addr;
                    ret_addr = mem_addr; ret_in = ret_dly; outst = 1;
                end else begin rd_w++; rd_pend = 1; end
            end
            if (mem_wr_valid) begin
                if (wr_w >= wr_dly) begin
                    mem_wr_ready = 1; obs_writes++; obs_wdata = mem_wdata; obs_wr_addr = mem_addr;
                    mem[mem_addr] = mem_wdata;
                end else begin wr_w++; wr_pend = 1; end
            end
            if (expect_err ? (n >= 4) : (obs_done_cyc >= 0 && n > obs_done_cyc)) break;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL reset_st_ready: got %b expected 1", st_ready); end
        checks++; if ({st_done, st_err} !== 2'b00) begin failures++; $display("FAIL reset_pulses: got %b expected 00", {st_done, st_err}); end
        checks++; if ({mem_rd_valid, mem_wr_valid} !== 2'b00) begin failures++; $display("FAIL reset_valids: got %b expected 00", {mem_rd_valid, mem_wr_valid}); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        rst = 0;
    endtask

    task automatic test_sb();
        bit lg; int er, el; logic [31:0] ew, ewa;
        mem[32'h1000] = 32'h11223344; ref_mem[32'h1000] = 32'h11223344;
        model_store(3'b000, 32'h1003, 32'h123456AB, 0, 1, 0, lg, er, el, ew, ewa);
        do_store(3'b000, 32'h1003, 32'h123456AB, 0, 1, 0, 0, 0);
        checks++; if (obs_reads !== 1 || obs_rd_addr !== 32'h1000) begin failures++; $display("FAIL sb_read: got %0d reads at %h expected 1 at 00001000", obs_reads, obs_rd_addr); end
        checks++; if (obs_wdata !== 32'hAB223344) begin failures++; $display("FAIL sb_wdata: got %h expected ab223344", obs_wdata); end
        checks++; if (obs_wr_addr !== 32'h1000) begin failures++; $display("FAIL sb_wr_addr: got %h expected 00001000", obs_wr_addr); end
        checks++; if (obs_done_cyc !== 4) begin failures++; $display("FAIL sb_latency: got %0d expected 4", obs_done_cyc); end
        checks++; if (obs_done_cnt !== 1 || obs_bad !== 0 || obs_ready_after !== 1'b1) begin failures++; $display("FAIL sb_protocol: got done=%0d bad=%0d ready=%b expected 1 0 1", obs_done_cnt, obs_bad, obs_ready_after); end
    endtask

    task automatic test_sh();
        bit lg; int er, el; logic [31:0] ew, ewa;
        mem[32'h2000] = 32'h11223344; ref_mem[32'h2000] = 32'h11223344;
        model_store(3'b001, 32'h2002, 32'h0000BEEF, 0, 1, 0, lg, er, el, ew, ewa);
        do_store(3'b001, 32'h2002, 32'h0000BEEF, 0, 1, 0, 0, 0);
        checks++; if (obs_wdata !== 32'hBEEF3344) begin failures++; $display("FAIL sh_wdata: got %h expected beef3344", obs_wdata); end
        checks++; if (obs_done_cyc !== 4 || obs_reads !== 1) begin failures++; $display("FAIL sh_timing: got lat=%0d reads=%0d expected 4 1", obs_done_cyc, obs_reads); end
        do_store(3'b001, 32'h2001, 32'h0000BEEF, 0, 1, 0, 1, 0);
        checks++; if (obs_err_cnt !== 1 || obs_err_cyc !== 1) begin failures++; $display("FAIL sh_misaligned_err: got count=%0d cycle=%0d expected 1 1", obs_err_cnt, obs_err_cyc); end
        checks++; if (obs_reads + obs_writes + obs_done_cnt !== 0) begin failures++; $display("FAIL sh_misaligned_traffic: got %0d events expected 0", obs_reads + obs_writes + obs_done_cnt); end
    endtask

    task automatic test_sw();
        bit lg; int er, el; logic [31:0] ew, ewa;
        model_store(3'b010, 32'h3000, 32'hDEADBEEF, 0, 1, 0, lg, er, el, ew, ewa);
        do_store(3'b010, 32'h3000, 32'hDEADBEEF, 0, 1, 0, 0, 0);
        checks++; if (obs_reads !== 0) begin failures++; $display("FAIL sw_no_read: got %0d reads expected 0", obs_reads); end
        checks++; if (obs_wdata !== 32'hDEADBEEF || obs_wr_addr !== 32'h3000) begin failures++; $display("FAIL sw_write: got %h at %h expected deadbeef at 00003000", obs_wdata, obs_wr_addr); end
        checks++; if (obs_done_cyc !== 2) begin failures++; $display("FAIL sw_latency: got %0d expected 2", obs_done_cyc); end
        do_store(3'b011, 32'h3000, 32'h1, 0, 1, 0, 1, 0);
        checks++; if (obs_err_cnt !== 1 || obs_err_cyc !== 1 || obs_reads + obs_writes !== 0) begin failures++; $display("FAIL funct3_illegal: got err=%0d cyc=%0d traffic=%0d expected 1 1 0", obs_err_cnt, obs_err_cyc, obs_reads + obs_writes); end
    endtask

    task automatic test_stall();
        bit lg; int er, el; logic [31:0] ew, ewa;
        mem[32'h6000] = 32'hCAFEF00D; ref_mem[32'h6000] = 32'hCAFEF00D;
        model_store(3'b000, 32'h6001, 32'h5A5A5AC3, 3, 2, 2, lg, er, el, ew, ewa);
        do_store(3'b000, 32'h6001, 32'h5A5A5AC3, 3, 2, 2, 0, 0);
        checks++; if (obs_bad !== 0) begin failures++; $display("FAIL stall_protocol: got %0d violations expected 0", obs_bad); end
        checks++; if (obs_done_cnt !== 1 || obs_done_cyc !== 10) begin failures++; $display("FAIL stall_done: got count=%0d cycle=%0d expected 1 10", obs_done_cnt, obs_done_cyc); end
        checks++; if (obs_wdata !== 32'hCAFEC30D) begin failures++; $display("FAIL stall_wdata: got %h expected cafec30d", obs_wdata); end
    endtask

    task automatic test_reset_mid();
        int bad_events;
        bad_events = 0;
        mem[32'h5000] = 32'h0BADF00D;
        @(negedge clk);
        st_valid = 1; st_funct3 = 3'b000; st_addr = 32'h5002; st_data = 32'h77;
        @(negedge clk);
        st_valid = 0;
        checks++; if (mem_rd_valid !== 1'b1) begin failures++; $display("FAIL rstmid_rd_valid: got %b expected 1", mem_rd_valid); end
        mem_rd_ready = 1;
        @(negedge clk);
        mem_rd_ready = 0;
        rst = 1;
        #1;
        checks++; if ({st_ready, st_done, st_err, mem_rd_valid, mem_wr_valid} !== 5'b10000) begin failures++; $display("FAIL rstmid_ctrl: got %b expected 10000", {st_ready, st_done, st_err, mem_rd_valid, mem_wr_valid}); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL rstmid_regs: got addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata); end
        @(negedge clk);
        rst = 0; mem_rdata_valid = 1; mem_rdata = 32'h12345678;
        last_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_rdata_valid = 0;
            if (mem_wr_valid || mem_rd_valid || st_done || !st_ready) bad_events++;
        end
        checks++; if (bad_events !== 0) begin failures++; $display("FAIL rstmid_after: got %0d bad cycles expected 0", bad_events); end
    endtask

`ifdef STORE_MERGE_FWD_EN
    task automatic test_fwd();
        bit lg; int er, el; logic [31:0] ew, ewa;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        last_valid = 1'b0;
        mem[32'h4000] = 32'h0; ref_mem[32'h4000] = 32'h0;
        model_store(3'b000, 32'h4000, 32'h55, 0, 1, 0, lg, er, el, ew, ewa);
        do_store(3'b000, 32'h4000, 32'h55, 0, 1, 0, 0, 0);
        checks++; if (obs_reads !== 1 || obs_wdata !== 32'h55) begin failures++; $display("FAIL fwd_first: got reads=%0d wdata=%h expected 1 00000055", obs_reads, obs_wdata); end
        mem[32'h4000] = 32'hFFFFFFFF;
        model_store(3'b000, 32'h4001, 32'h66, 0, 1, 0, lg, er, el, ew, ewa);
        do_store(3'b000, 32'h4001, 32'h66, 0, 1, 0, 0, 0);
        checks++; if (obs_reads !== 0) begin failures++; $display("FAIL fwd_no_read: got %0d reads expected 0", obs_reads); end
        checks++; if (obs_wdata !== 32'h00006655 || obs_done_cyc !== 2) begin failures++; $display("FAIL fwd_hit: got wdata=%h lat=%0d expected 00006655 2", obs_wdata, obs_done_cyc); end
        mem[32'h4000] = 32'h00006655;
    endtask
`endif

    task automatic test_random();
        bit lg; int er, el; logic [31:0] ew, ewa;
        logic [2:0] f3; logic [31:0] addr, data;
        int rd, ret, wr;
        for (int w = 0; w < 4; w++) begin
            addr = 32'h8000 + 32'(4 * w);
            data = $urandom;
            mem[addr] = data; ref_mem[addr] = data;
        end
        for (int it = 0; it < 40; it++) begin
            f3 = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            addr = 32'h8000 + $urandom_range(0, 15);
            data = $urandom;
            rd = $urandom_range(0, 2); ret = $urandom_range(1, 3); wr = $urandom_range(0, 2);
            model_store(f3, addr, data, rd, ret, wr, lg, er, el, ew, ewa);
            do_store(f3, addr, data, rd, ret, wr, !lg, 1'($urandom_range(0, 1)));
            if (lg) begin
                checks++; if (obs_writes !== 1 || obs_wr_addr !== ewa) begin failures++; $display("FAIL rand_write[%0d]: got %0d at %h expected 1 at %h", it, obs_writes, obs_wr_addr, ewa); end
                checks++; if (obs_reads !== er) begin failures++; $display("FAIL rand_reads[%0d]: got %0d expected %0d", it, obs_reads, er); end
                checks++; if (obs_wdata !== ew) begin failures++; $display("FAIL rand_wdata[%0d]: got %h expected %h", it, obs_wdata, ew); end
                checks++; if (obs_done_cyc !== el || obs_done_cnt !== 1) begin failures++; $display("FAIL rand_done[%0d]: got cyc=%0d cnt=%0d expected %0d 1", it, obs_done_cyc, obs_done_cnt, el); end
                checks++; if (obs_bad !== 0 || obs_err_cnt !== 0) begin failures++; $display("FAIL rand_protocol[%0d]: got bad=%0d err=%0d expected 0 0", it, obs_bad, obs_err_cnt); end
            end else begin
                checks++; if (obs_err_cnt !== 1 || obs_err_cyc !== 1) begin failures++; $display("FAIL rand_err[%0d]: got count=%0d cycle=%0d expected 1 1", it, obs_err_cnt, obs_err_cyc); end
                checks++; if (obs_reads + obs_writes + obs_done_cnt !== 0) begin failures++; $display("FAIL rand_err_traffic[%0d]: got %0d expected 0", it, obs_reads + obs_writes + obs_done_cnt); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_sw();
        test_stall();
        test_reset_mid();
`ifdef STORE_MERGE_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
